imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Takes an instruction word and a format select, and produces the sign-extended immediate at XLEN width one cycle later. A valid/ready handshake on each side carries a sideband tag through the block. A two-entry skid buffer keeps full throughput under backpressure. Out-of-range formats raise an illegal flag instead of producing an undefined value.

---
 rtl/imm_gen_pipe.sv | 140 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready handshakes and a two-entry skid buffer.
// Optional build macro: IMM_ZICSR_EN enables the csr zimm (Z) format on extop 101.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_extop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [XLEN-1:0]    main_imm_reg;
  logic               main_illegal_reg;
  logic [TAG_W-1:0]   main_tag_reg;
  logic [XLEN-1:0]    skid_imm_reg;
  logic               skid_illegal_reg;
  logic [TAG_W-1:0]   skid_tag_reg;

  logic [31:0]        imm32_next;
  logic               illegal_next;
  logic [XLEN-1:0]    imm_next;
  logic               in_fire;
  logic               out_fire;
  logic               unused_opcode;

  assign unused_opcode = ^in_instr[6:0];

  // Every format produces a 32-bit value whose bit 31 is the correct extension bit.
  always_comb begin
    imm32_next   = '0;
    illegal_next = 1'b0;
    case (in_extop)
      3'b000: imm32_next = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001: imm32_next = {in_instr[31:12], 12'b0};
      3'b010: imm32_next = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b011: imm32_next = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
      3'b100: imm32_next = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      3'b101: imm32_next = {27'd0, in_instr[19:15]};
`endif
      default: illegal_next = 1'b1;
    endcase
  end

  assign imm_next[31:0] = imm32_next;

  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi = gi + 1) begin : g_sext
      assign imm_next[gi] = imm32_next[31];
    end
  endgenerate

  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= EMPTY;
      in_ready_reg     <= 1'b1;
      out_valid_reg    <= 1'b0;
      main_imm_reg     <= '0;
      main_illegal_reg <= 1'b0;
      main_tag_reg     <= '0;
      skid_imm_reg     <= '0;
      skid_illegal_reg <= 1'b0;
      skid_tag_reg     <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_imm_reg     <= imm_next;
            main_illegal_reg <= illegal_next;
            main_tag_reg     <= in_tag;
            state_reg        <= ONE;
            out_valid_reg    <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_imm_reg     <= imm_next;
            skid_illegal_reg <= illegal_next;
            skid_tag_reg     <= in_tag;
            state_reg        <= TWO;
            in_ready_reg     <= 1'b0;
          end else if (in_fire) begin
            // Old main leaves this edge, so the new beat replaces it with no bubble.
            main_imm_reg     <= imm_next;
            main_illegal_reg <= illegal_next;
            main_tag_reg     <= in_tag;
          end else if (out_fire) begin
            state_reg        <= EMPTY;
            out_valid_reg    <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_imm_reg     <= skid_imm_reg;
            main_illegal_reg <= skid_illegal_reg;
            main_tag_reg     <= skid_tag_reg;
            state_reg        <= ONE;
            in_ready_reg     <= 1'b1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_imm     = main_imm_reg;
  assign out_illegal = main_illegal_reg;
  assign out_tag     = main_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances share stimulus and are checked
// against a format-level reference model and a FIFO scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_extop;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_extop(in_extop), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_extop(in_extop), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_in_fire;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [2:0] op,
                                 input logic [7:0] tg);
    exp_t e;
    e.tag = tg;
    e.ill = 1'b0;
    e.imm = '0;
    case (op)
      3'd0: e.imm = 64'($signed(i[31:20]));
      3'd1: e.imm = 64'($signed({i[31:12], 12'b0}));
      3'd2: e.imm = 64'($signed({i[31:25], i[11:7]}));
      3'd3: e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4: e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
`ifdef IMM_ZICSR_EN
      3'd5: e.imm = 64'(i[19:15]);
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: drive inputs, check at negedge against the model, update scoreboard.
  task automatic drive_cycle(input bit v, input logic [31:0] ins, input logic [2:0] op,
                             input logic [7:0] tg, input bit ordy);
    bit inf, outf;
    in_valid = v; in_instr = ins; in_extop = op; in_tag = tg; out_ready = ordy;
    @(negedge clk);
    inf  = v && (q.size() < 2);
    outf = (q.size() != 0) && ordy;
    chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("imm32", 64'(out_imm32), 64'(q[0].imm[31:0]));
      chk("imm64", out_imm64, q[0].imm);
      chk("ill32", 64'(out_illegal32), 64'(q[0].ill));
      chk("ill64", 64'(out_illegal64), 64'(q[0].ill));
      chk("tag32", 64'(out_tag32), 64'(q[0].tag));
      chk("tag64", 64'(out_tag64), 64'(q[0].tag));
    end
    last_in_fire = inf && !rst;
    if (rst) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(model(ins, op, tg));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) drive_cycle(1'b0, '0, '0, '0, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] vin  [5];
    logic [2:0]  vop  [5];
    logic [31:0] vexp [5];
    int k;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_extop = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    chk("rst_imm", 64'(out_imm32), 64'd0);
    chk("rst_tag", 64'(out_tag32), 64'd0);
    chk("rst_ill", 64'(out_illegal32), 64'd0);

    // Back-to-back formats; each result visible right after its accepting edge.
    vin[0] = 32'hFFF00093; vop[0] = 3'd0; vexp[0] = 32'hFFFFFFFF;
    vin[1] = 32'h123450B7; vop[1] = 3'd1; vexp[1] = 32'h12345000;
    vin[2] = 32'hFE000EE3; vop[2] = 3'd3; vexp[2] = 32'hFFFFFFFC;
    vin[3] = 32'h0080006F; vop[3] = 3'd4; vexp[3] = 32'h00000008;
    vin[4] = 32'h800000B7; vop[4] = 3'd1; vexp[4] = 32'h80000000;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, vin[i], vop[i], 8'(i + 16), 1'b1);
      chk("fmt_imm", 64'(out_imm32), 64'(vexp[i]));
      chk("fmt_tag", 64'(out_tag32), 64'(i + 16));
    end
    chk("u64_imm", out_imm64, 64'hFFFFFFFF80000000);

    drive_cycle(1'b1, 32'h12345678, 3'd7, 8'h30, 1'b1);
    chk("illegal_imm", 64'(out_imm32), 64'd0);
    chk("illegal_flag", 64'(out_illegal32), 64'd1);
    drive_cycle(1'b1, 32'h0052D073, 3'd5, 8'h31, 1'b1);
`ifdef IMM_ZICSR_EN
    chk("z_imm", out_imm64, 64'd5);
    chk("z_flag", 64'(out_illegal64), 64'd0);
`else
    chk("z_imm", out_imm64, 64'd0);
    chk("z_flag", 64'(out_illegal64), 64'd1);
`endif
    drain();

    // Backpressure: tags 1..6 offered continuously, consumer stalled 4 cycles.
    k = 1;
    for (int c = 0; c < 40 && !(k > 6 && q.size() == 0); c++) begin
      drive_cycle(k <= 6, $urandom, 3'($urandom_range(0, 4)), 8'(k), c >= 4);
      if (last_in_fire) k++;
      if (c == 3) chk("bp_accepted", 64'(k - 1), 64'd2);
    end
    chk("bp_done", 64'(k > 6 && q.size() == 0), 64'd1);

    // Reset while holding two entries.
    drive_cycle(1'b1, $urandom, 3'd0, 8'h41, 1'b0);
    drive_cycle(1'b1, $urandom, 3'd2, 8'h42, 1'b0);
    chk("pre_rst_full", 64'(in_ready32), 64'd0);
    rst = 1'b1;
    drive_cycle(1'b1, $urandom, 3'd1, 8'h43, 1'b0);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid32), 64'd0);
    chk("mid_rst_ready", 64'(in_ready32), 64'd1);
    chk("mid_rst_imm", out_imm64, 64'd0);
    chk("mid_rst_tag", 64'(out_tag64), 64'd0);
    chk("mid_rst_ill", 64'(out_illegal64), 64'd0);
    drive_cycle(1'b1, 32'hFFF00093, 3'd0, 8'h77, 1'b1);
    chk("post_rst_tag", 64'(out_tag32), 64'h77);
    drain();

    // Random stress.
    for (int c = 0; c < 10000; c++)
      drive_cycle(1'($urandom), $urandom, 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
